// File: rtl/mram_power_manager.sv
// Request-level power manager for the MRAM macro; drives the power-gate sequencer's power level.
// Optional idle auto-sleep is built only when MRAM_PM_AUTO_SLEEP_EN is defined.
module mram_power_manager #(
   parameter int unsigned IDLE_CNT_W  = 16,
   parameter int unsigned TO_CNT_W    = 8,
   parameter int unsigned TIMEOUT_CYC = 200
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wake_req,
   input  logic                  sleep_req,
   input  logic                  acc_req,
   output logic                  acc_gnt,
   input  logic                  auto_sleep_en,
   input  logic [IDLE_CNT_W-1:0] idle_limit,
   input  logic                  err_clr,
   output logic                  fsm_power,
   input  logic                  fsm_done,
   input  logic                  fsm_isolate,
   output logic                  ready,
   output logic                  busy,
   output logic                  err
);

   typedef enum logic [2:0] {
      StOff,
      StPowerUp,
      StOn,
      StPowerDown,
      StErr
   } state_e;

   state_e                state_q, state_d;
   logic                  blank_q, blank_d;
   logic [TO_CNT_W-1:0]   to_cnt_q, to_cnt_d;
   logic                  wake_pend_q, wake_pend_d;
   logic                  fsm_power_q, fsm_power_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  err_q, err_d;
   logic                  auto_sleep;
   logic                  wake_any;
   logic                  to_expired;

   assign wake_any   = wake_req | acc_req;
   assign to_expired = (to_cnt_q == TO_CNT_W'(TIMEOUT_CYC - 1));

`ifdef MRAM_PM_AUTO_SLEEP_EN
   logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [IDLE_CNT_W-1:0] idle_inc;

   assign idle_inc   = (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + 1'b1;
   // Fires on the cycle that completes idle_limit consecutive idle cycles.
   assign auto_sleep = auto_sleep_en && (idle_limit != '0) && (idle_inc == idle_limit);

   always_comb begin
      idle_cnt_d = '0;
      if (state_q == StOn && state_d == StOn && !acc_req) begin
         idle_cnt_d = idle_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg = ^{auto_sleep_en, idle_limit};
   assign auto_sleep = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      to_cnt_d    = '0;
      wake_pend_d = wake_pend_q;
      unique case (state_q)
         StOff: begin
            if (wake_any || wake_pend_q) begin
               state_d     = StPowerUp;
               wake_pend_d = 1'b0;
            end
         end
         StPowerUp: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (!blank_q && fsm_done && !fsm_isolate) begin
               state_d = StOn;
            end else if (to_expired) begin
               state_d = StErr;
            end
         end
         StOn: begin
            if (!acc_req && (sleep_req || auto_sleep)) begin
               state_d = StPowerDown;
            end
         end
         StPowerDown: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (wake_any) begin
               wake_pend_d = 1'b1;
            end
            if (!blank_q && fsm_done) begin
               state_d = StOff;
            end else if (to_expired) begin
               state_d = StErr;
            end
         end
         StErr: begin
            if (err_clr && fsm_done) begin
               state_d = StOff;
            end
         end
         default: state_d = StOff;
      endcase

      // done is combinational on power, so the first cycle of a transition carries a stale value.
      blank_d     = (state_d != state_q) &&
                    (state_d == StPowerUp || state_d == StPowerDown);
      fsm_power_d = (state_d == StPowerUp) || (state_d == StOn);
      ready_d     = (state_d == StOn);
      busy_d      = (state_d == StPowerUp) || (state_d == StPowerDown);
      err_d       = (state_d == StErr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StOff;
         blank_q     <= 1'b0;
         to_cnt_q    <= '0;
         wake_pend_q <= 1'b0;
         fsm_power_q <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         blank_q     <= blank_d;
         to_cnt_q    <= to_cnt_d;
         wake_pend_q <= wake_pend_d;
         fsm_power_q <= fsm_power_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign fsm_power = fsm_power_q;
   assign ready     = ready_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign acc_gnt   = acc_req & ready_q;

endmodule

// File: tb/tb_mram_power_manager.sv
// Directed self-checking bench for mram_power_manager; outs vector is {fsm_power, ready, busy, err}.
module tb_mram_power_manager;

   logic        clk = 1'b0;
   logic        rst;
   logic        wake_req, sleep_req, acc_req, acc_gnt;
   logic        auto_sleep_en;
   logic [15:0] idle_limit;
   logic        err_clr;
   logic        fsm_power, fsm_done, fsm_isolate;
   logic        ready, busy, err;
   logic [3:0]  outs;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign outs = {fsm_power, ready, busy, err};

   mram_power_manager dut (
      .clk          (clk),
      .rst          (rst),
      .wake_req     (wake_req),
      .sleep_req    (sleep_req),
      .acc_req      (acc_req),
      .acc_gnt      (acc_gnt),
      .auto_sleep_en(auto_sleep_en),
      .idle_limit   (idle_limit),
      .err_clr      (err_clr),
      .fsm_power    (fsm_power),
      .fsm_done     (fsm_done),
      .fsm_isolate  (fsm_isolate),
      .ready        (ready),
      .busy         (busy),
      .err          (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outs(input string name, input logic [3:0] exp);
      total++;
      if (outs !== exp) begin
         bad++;
         $display("FAIL %s: outs got %b want %b", name, outs, exp);
      end
   endtask

   task automatic chk_gnt(input string name, input logic exp);
      #1;
      total++;
      if (acc_gnt !== exp) begin
         bad++;
         $display("FAIL %s: acc_gnt got %b want %b", name, acc_gnt, exp);
      end
   endtask

   // Both helpers assume fsm_done is held at 1 (sequencer settled instantly).
   task automatic go_on();
      wake_req = 1'b1;
      tick();
      wake_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic go_off();
      sleep_req = 1'b1;
      tick();
      sleep_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk_outs("reset_outs", 4'b0000);
      chk_gnt("reset_gnt", 1'b0);
   endtask

   task automatic test_wake_sleep();
      wake_req = 1'b1;
      tick();
      chk_outs("wake_power_1cyc", 4'b1010);
      wake_req = 1'b0;
      fsm_done = 1'b1;
      tick();
      chk_outs("wake_blank_ignored", 4'b1010);
      fsm_done = 1'b0;
      repeat (12) tick();
      fsm_done    = 1'b1;
      fsm_isolate = 1'b1;
      tick();
      chk_outs("wake_isolated_hold", 4'b1010);
      fsm_isolate = 1'b0;
      tick();
      chk_outs("wake_ready", 4'b1100);
      acc_req = 1'b1;
      chk_gnt("gnt_follow_hi", 1'b1);
      acc_req = 1'b0;
      chk_gnt("gnt_follow_lo", 1'b0);
      sleep_req = 1'b1;
      tick();
      chk_outs("sleep_power_down", 4'b0010);
      sleep_req = 1'b0;
      tick();
      chk_outs("sleep_blank_ignored", 4'b0010);
      fsm_done = 1'b0;
      repeat (3) tick();
      chk_outs("sleep_wait_done", 4'b0010);
      fsm_done = 1'b1;
      tick();
      chk_outs("sleep_off", 4'b0000);
      tick();
      chk_outs("sleep_stays_off", 4'b0000);
   endtask

   task automatic test_simultaneous();
      wake_req  = 1'b1;
      sleep_req = 1'b1;
      tick();
      chk_outs("sim_off_wake_wins", 4'b1010);
      wake_req  = 1'b0;
      sleep_req = 1'b0;
      tick();
      tick();
      chk_outs("sim_reach_on", 4'b1100);
      wake_req  = 1'b1;
      sleep_req = 1'b1;
      tick();
      chk_outs("sim_on_sleep_wins", 4'b0010);
      wake_req  = 1'b0;
      sleep_req = 1'b0;
      tick();
      tick();
      chk_outs("sim_back_off", 4'b0000);
   endtask

   task automatic test_acc_priority();
      go_on();
      sleep_req = 1'b1;
      acc_req   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk_gnt($sformatf("prio_gnt_%0d", i), 1'b1);
         chk_outs($sformatf("prio_on_%0d", i), 4'b1100);
         tick();
      end
      acc_req = 1'b0;
      chk_outs("prio_still_on_6th", 4'b1100);
      tick();
      chk_outs("prio_down_after_6th", 4'b0010);
      sleep_req = 1'b0;
      tick();
      tick();
      chk_outs("prio_off", 4'b0000);
   endtask

   task automatic test_auto_sleep();
      auto_sleep_en = 1'b1;
      idle_limit    = 16'd10;
      go_on();
`ifdef MRAM_PM_AUTO_SLEEP_EN
      repeat (9) tick();
      chk_outs("auto_on_9", 4'b1100);
      tick();
      chk_outs("auto_fall_10", 4'b0010);
      tick();
      tick();
      go_on();
      repeat (8) tick();
      acc_req = 1'b1;
      tick();
      acc_req = 1'b0;
      repeat (9) tick();
      chk_outs("auto_pulse_on_9", 4'b1100);
      tick();
      chk_outs("auto_pulse_fall_10", 4'b0010);
      tick();
      tick();
`else
      repeat (30) tick();
      chk_outs("auto_ignored", 4'b1100);
      go_off();
`endif
      idle_limit = 16'd0;
      go_on();
      repeat (30) tick();
      chk_outs("auto_limit0_disabled", 4'b1100);
      go_off();
      chk_outs("auto_done_off", 4'b0000);
      auto_sleep_en = 1'b0;
   endtask

   task automatic test_pending_wake();
      go_on();
      sleep_req = 1'b1;
      tick();
      sleep_req = 1'b0;
      acc_req   = 1'b1;
      chk_gnt("pend_no_gnt", 1'b0);
      tick();
      acc_req = 1'b0;
      tick();
      chk_outs("pend_off_1cyc", 4'b0000);
      tick();
      chk_outs("pend_power_up", 4'b1010);
      tick();
      tick();
      chk_outs("pend_on", 4'b1100);
      go_off();
   endtask

   task automatic test_timeout();
      fsm_done = 1'b0;
      wake_req = 1'b1;
      tick();
      wake_req = 1'b0;
      repeat (199) tick();
      chk_outs("to_before_199", 4'b1010);
      tick();
      chk_outs("to_err_200", 4'b0001);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk_outs("to_clr_no_done", 4'b0001);
      fsm_done = 1'b1;
      err_clr  = 1'b1;
      tick();
      err_clr = 1'b0;
      chk_outs("to_clr_done", 4'b0000);
      tick();
      chk_outs("to_off_stays", 4'b0000);
   endtask

   task automatic test_reset_mid();
      fsm_done = 1'b0;
      wake_req = 1'b1;
      tick();
      wake_req = 1'b0;
      repeat (4) tick();
      chk_outs("rst_mid_powering", 4'b1010);
      rst     = 1'b1;
      acc_req = 1'b1;
      tick();
      chk_outs("rst_mid_outs", 4'b0000);
      chk_gnt("rst_mid_gnt", 1'b0);
      acc_req = 1'b0;
      rst     = 1'b0;
      tick();
      chk_outs("rst_mid_idle", 4'b0000);
   endtask

   initial begin
      rst           = 1'b1;
      wake_req      = 1'b0;
      sleep_req     = 1'b0;
      acc_req       = 1'b0;
      auto_sleep_en = 1'b0;
      idle_limit    = 16'd0;
      err_clr       = 1'b0;
      fsm_done      = 1'b0;
      fsm_isolate   = 1'b0;
      test_reset();
      test_wake_sleep();
      test_simultaneous();
      test_acc_priority();
      test_auto_sleep();
      test_pending_wake();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
